pixel_disc_counter: RTL and testbench

//   Per-pixel photon counting stage directly downstream of the sensor discriminators.
//   - Synchronises the two async discriminator outputs, discOutLocal and discOutSum.
//   - Rejects glitches, then counts one hit per qualified pulse in each channel.
//   - Continuous (dead-time-free) readout: on frameSwap, live counts move to a shadow

---
 rtl/pixel_pkg.sv | 34 +++
 rtl/disc_qualifier.sv | 92 +++++++++
 rtl/pixel_disc_counter.sv | 142 ++++++++++++++
 tb/tb_pixel_disc_counter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel discriminator counter.
// Build option: define PIXEL_COINC_EN in the top to add the coincidence counter.
package pixel_pkg;

  // Widest counter the shared frame type can carry; CNT_W must not exceed it.
  localparam int unsigned CNT_W_MAX = 32;

  // Per-channel pulse qualifier states.
  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    ARMED,
    HIGH
  } qual_state_t;

  // One channel's frame: hit count plus saturation flag.
  typedef struct packed {
    logic [CNT_W_MAX-1:0] cnt;
    logic                 sat;
  } frame_t;

  // Saturating increment: at max_cnt the count holds and the sat flag is raised.
  function automatic frame_t sat_inc(frame_t cur, logic [CNT_W_MAX-1:0] max_cnt);
    frame_t res;
    res = cur;
    if (cur.cnt >= max_cnt) begin
      res.sat = 1'b1;
    end else begin
      res.cnt = cur.cnt + CNT_W_MAX'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/disc_qualifier.sv
// Synchronises one async discriminator output and emits one hit per pulse that stays
// high for at least MIN_WIDTH synchronised cycles.
module disc_qualifier
  import pixel_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_WIDTH   = 2
) (
  input  logic clock,
  input  logic rstn,
  input  logic discIn,
  output logic hit,
  output logic busy
);

  localparam int unsigned RunW = $clog2(MIN_WIDTH + 1);
  localparam logic [RunW-1:0] RunTarget = RunW'(MIN_WIDTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   s;
  logic                   primed;
  qual_state_t            state_q, state_d;
  logic [RunW-1:0]        run_q, run_d;

  assign s      = sync_q[SYNC_STAGES-1];
  // Only trust s once it carries a sample taken after reset release.
  assign primed = primed_q[SYNC_STAGES-1];

  // Synchroniser chain and a matching marker of which stages hold real samples.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= '0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], discIn};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Qualifier state and run counter registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT_LOW;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic; hit is a single-cycle pulse on entry to HIGH.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hit     = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (primed && !s) state_d = IDLE;
      end
      IDLE: begin
        if (s) begin
          if (MIN_WIDTH == 1) begin
            state_d = HIGH;
            hit     = 1'b1;
          end else begin
            state_d = ARMED;
            run_d   = RunW'(1);
          end
        end
      end
      ARMED: begin
        if (!s) begin
          state_d = IDLE;
        end else begin
          run_d = run_q + RunW'(1);
          if (run_d == RunTarget) begin
            state_d = HIGH;
            hit     = 1'b1;
          end
        end
      end
      HIGH: begin
        if (!s) state_d = IDLE;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  assign busy = (state_q == ARMED) || (state_q == HIGH);

endmodule

// File: rtl/pixel_disc_counter.sv
// Per-pixel photon counter: two qualified discriminator channels counted into live
// registers, swapped into a valid/ready shadow on frameSwap without dead time.
// Build option: PIXEL_COINC_EN adds a coincidence counter and the rdCoinc port.
module pixel_disc_counter
  import pixel_pkg::*;
#(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_WIDTH   = 2
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             discOutLocal,
  input  logic             discOutSum,
  input  logic             enable,
  input  logic             frameSwap,
  output logic             rdValid,
  input  logic             rdReady,
  output logic [CNT_W-1:0] rdLocal,
  output logic [CNT_W-1:0] rdSum,
`ifdef PIXEL_COINC_EN
  output logic [CNT_W-1:0] rdCoinc,
  output logic [2:0]       rdSat,
`else
  output logic [1:0]       rdSat,
`endif
  output logic             overrun
);

`ifdef PIXEL_COINC_EN
  localparam int unsigned NumCh = 3;
`else
  localparam int unsigned NumCh = 2;
`endif
  localparam logic [CNT_W_MAX-1:0] MaxCnt = CNT_W_MAX'({CNT_W{1'b1}});

  logic hit_local, hit_sum, busy_local, busy_sum;
  logic unused_busy;

  logic [NumCh-1:0]            inc;
  logic [NumCh-1:0][CNT_W-1:0] live_q, live_d, shadow_q;
  logic [NumCh-1:0]            live_sat_q, live_sat_d, shadow_sat_q;
  logic                        rd_valid_q, overrun_q;
  logic                        load_shadow;

  disc_qualifier #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_WIDTH  (MIN_WIDTH)
  ) u_qual_local (
    .clock (clock),
    .rstn  (rstn),
    .discIn(discOutLocal),
    .hit   (hit_local),
    .busy  (busy_local)
  );

  disc_qualifier #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_WIDTH  (MIN_WIDTH)
  ) u_qual_sum (
    .clock (clock),
    .rstn  (rstn),
    .discIn(discOutSum),
    .hit   (hit_sum),
    .busy  (busy_sum)
  );

  assign inc[0] = hit_local & enable;
  assign inc[1] = hit_sum & enable;
`ifdef PIXEL_COINC_EN
  // A local hit is coincident while the sum channel is inside a pulse.
  assign inc[2]      = hit_local & busy_sum & enable;
  assign unused_busy = busy_local;
`else
  assign unused_busy = busy_local ^ busy_sum;
`endif

  // Shadow only takes a new frame if the previous one is gone or being read now.
  assign load_shadow = frameSwap & (~rd_valid_q | rdReady);

  // Live counters: saturating count, restarted on every swap with the swap-cycle hit.
  always_comb begin : p_live_next
    frame_t cur;
    frame_t nxt;
    live_d     = live_q;
    live_sat_d = live_sat_q;
    for (int c = 0; c < NumCh; c++) begin
      cur.cnt = CNT_W_MAX'(live_q[c]);
      cur.sat = live_sat_q[c];
      nxt     = sat_inc(cur, MaxCnt);
      if (frameSwap) begin
        live_d[c]     = CNT_W'(inc[c]);
        live_sat_d[c] = 1'b0;
      end else if (inc[c]) begin
        live_d[c]     = CNT_W'(nxt.cnt);
        live_sat_d[c] = nxt.sat;
      end
    end
  end

  // Live counter registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      live_q     <= '0;
      live_sat_q <= '0;
    end else begin
      live_q     <= live_d;
      live_sat_q <= live_sat_d;
    end
  end

  // Shadow, valid/ready handshake and sticky overrun.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      shadow_q     <= '0;
      shadow_sat_q <= '0;
      rd_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (load_shadow) begin
        shadow_q     <= live_q;
        shadow_sat_q <= live_sat_q;
      end
      if (frameSwap) begin
        rd_valid_q <= 1'b1;
        if (!load_shadow) overrun_q <= 1'b1;
      end else if (rd_valid_q && rdReady) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign rdValid = rd_valid_q;
  assign overrun = overrun_q;
  assign rdLocal = shadow_q[0];
  assign rdSum   = shadow_q[1];
  assign rdSat   = shadow_sat_q;
`ifdef PIXEL_COINC_EN
  assign rdCoinc = shadow_q[2];
`endif

endmodule

// File: tb/tb_pixel_disc_counter.sv
// Bench for pixel_disc_counter: two instances (CNT_W=12 and CNT_W=4) share stimulus
// and are compared every cycle with a pulse-level reference model.
module tb_pixel_disc_counter;

  localparam int S = 2;
  localparam int M = 2;
`ifdef PIXEL_COINC_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  logic clock, rstn;
  logic disc_local, disc_sum, enable, frame_swap, rd_ready;
  logic rd_valid_a, overrun_a, rd_valid_b, overrun_b;
  logic [11:0] rd_local_a, rd_sum_a;
  logic [3:0]  rd_local_b, rd_sum_b;
  logic [NCH-1:0] rd_sat_a, rd_sat_b;
`ifdef PIXEL_COINC_EN
  logic [11:0] rd_coinc_a;
  logic [3:0]  rd_coinc_b;
`endif

  pixel_disc_counter #(.CNT_W(12), .SYNC_STAGES(S), .MIN_WIDTH(M)) dut (
    .clock(clock), .rstn(rstn), .discOutLocal(disc_local), .discOutSum(disc_sum),
    .enable(enable), .frameSwap(frame_swap), .rdValid(rd_valid_a), .rdReady(rd_ready),
    .rdLocal(rd_local_a), .rdSum(rd_sum_a),
`ifdef PIXEL_COINC_EN
    .rdCoinc(rd_coinc_a),
`endif
    .rdSat(rd_sat_a), .overrun(overrun_a)
  );

  pixel_disc_counter #(.CNT_W(4), .SYNC_STAGES(S), .MIN_WIDTH(M)) dut4 (
    .clock(clock), .rstn(rstn), .discOutLocal(disc_local), .discOutSum(disc_sum),
    .enable(enable), .frameSwap(frame_swap), .rdValid(rd_valid_b), .rdReady(rd_ready),
    .rdLocal(rd_local_b), .rdSum(rd_sum_b),
`ifdef PIXEL_COINC_EN
    .rdCoinc(rd_coinc_b),
`endif
    .rdSat(rd_sat_b), .overrun(overrun_b)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state, index 0 = 12-bit instance, 1 = 4-bit instance.
  int m_live[2][NCH];
  int m_sh[2][NCH];
  bit m_lsat[2][NCH];
  bit m_ssat[2][NCH];
  bit m_valid[2];
  bit m_ovr[2];
  int max_cnt[2] = '{4095, 15};
  int run[2];
  bit seen_low[2];
  int pend_l[$];
  int pend_s[$];
`ifdef PIXEL_COINC_EN
  bit qual_hi[int];
`endif
  int hi_left[2];
  int lo_left[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCH; c++) begin
        m_live[i][c] = 0; m_sh[i][c] = 0; m_lsat[i][c] = 0; m_ssat[i][c] = 0;
      end
      m_valid[i] = 0; m_ovr[i] = 0; run[i] = 0; seen_low[i] = 0;
    end
    pend_l.delete();
    pend_s.delete();
  endtask

  // One clock edge of behaviour: a pulse of >= M high samples, preceded by a low
  // sample since reset, is counted S+M-1 edges after its first high sample.
  task automatic model_edge();
    bit hit[NCH];
    bit smp[2];
    bit ld;
    for (int c = 0; c < NCH; c++) hit[c] = 0;
    if (pend_l.size() != 0 && pend_l[0] == cyc) begin hit[0] = 1; void'(pend_l.pop_front()); end
    if (pend_s.size() != 0 && pend_s[0] == cyc) begin hit[1] = 1; void'(pend_s.pop_front()); end
    smp[0] = disc_local;
    smp[1] = disc_sum;
`ifdef PIXEL_COINC_EN
    hit[2] = hit[0] && qual_hi.exists(cyc - S - 1) && qual_hi[cyc - S - 1];
    qual_hi[cyc] = smp[1] && seen_low[1];
`endif
    for (int c = 0; c < 2; c++) begin
      if (smp[c]) begin
        run[c]++;
        if (run[c] == M && seen_low[c]) begin
          if (c == 0) pend_l.push_back(cyc + S);
          else        pend_s.push_back(cyc + S);
        end
      end else begin
        run[c] = 0;
        seen_low[c] = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (frame_swap) begin
        ld = !m_valid[i] || rd_ready;
        if (ld) begin
          for (int c = 0; c < NCH; c++) begin
            m_sh[i][c] = m_live[i][c]; m_ssat[i][c] = m_lsat[i][c];
          end
        end else begin
          m_ovr[i] = 1;
        end
        m_valid[i] = 1;
        for (int c = 0; c < NCH; c++) begin
          m_live[i][c] = (hit[c] && enable) ? 1 : 0;
          m_lsat[i][c] = 0;
        end
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (hit[c] && enable) begin
            if (m_live[i][c] == max_cnt[i]) m_lsat[i][c] = 1;
            else m_live[i][c]++;
          end
        end
        if (m_valid[i] && rd_ready) m_valid[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] sat_pack(input int i);
    logic [31:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c] = m_ssat[i][c];
    return v;
  endfunction

  task automatic compare_all();
    check_eq("valid_a", rd_valid_a, m_valid[0]);
    check_eq("overrun_a", overrun_a, m_ovr[0]);
    check_eq("local_a", rd_local_a, m_sh[0][0]);
    check_eq("sum_a", rd_sum_a, m_sh[0][1]);
    check_eq("sat_a", rd_sat_a, sat_pack(0));
    check_eq("valid_b", rd_valid_b, m_valid[1]);
    check_eq("overrun_b", overrun_b, m_ovr[1]);
    check_eq("local_b", rd_local_b, m_sh[1][0]);
    check_eq("sum_b", rd_sum_b, m_sh[1][1]);
    check_eq("sat_b", rd_sat_b, sat_pack(1));
`ifdef PIXEL_COINC_EN
    check_eq("coinc_a", rd_coinc_a, m_sh[0][2]);
    check_eq("coinc_b", rd_coinc_b, m_sh[1][2]);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    if (!rstn) model_reset();
    else model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic set_ch(input int ch, input logic v);
    if (ch == 0) disc_local = v;
    else disc_sum = v;
  endtask

  task automatic drive_pulse(input int ch, input int width, input int gap);
    for (int k = 0; k < width; k++) begin set_ch(ch, 1'b1); tick(); end
    set_ch(ch, 1'b0);
    repeat (gap) tick();
  endtask

  task automatic do_swap();
    frame_swap = 1'b1;
    tick();
    frame_swap = 1'b0;
  endtask

  task automatic rand_drive();
    for (int c = 0; c < 2; c++) begin
      if (hi_left[c] > 0) begin
        set_ch(c, 1'b1);
        hi_left[c]--;
        if (hi_left[c] == 0) lo_left[c] = $urandom_range(1, 5);
      end else if (lo_left[c] > 0) begin
        set_ch(c, 1'b0);
        lo_left[c]--;
      end else begin
        set_ch(c, 1'b1);
        hi_left[c] = $urandom_range(1, 6) - 1;
        if (hi_left[c] == 0) lo_left[c] = $urandom_range(1, 5);
      end
    end
  endtask

  initial begin
    clock = 0; rstn = 1; disc_local = 0; disc_sum = 0;
    enable = 1; frame_swap = 0; rd_ready = 0;
    model_reset();
    #1 rstn = 0;
    #1 compare_all();
    tick(); tick();
    rstn = 1;
    repeat (4) tick();

    // 20 long local pulses in one frame.
    repeat (20) drive_pulse(0, 10, 2);
    repeat (4) tick();
    do_swap();
    check_eq("t1_valid", rd_valid_a, 1);
    check_eq("t1_local", rd_local_a, 20);
    check_eq("t1_sum", rd_sum_a, 0);
    rd_ready = 1; tick(); rd_ready = 0;
    check_eq("t1_consumed", rd_valid_a, 0);

    // Glitches on the sum channel are rejected, real pulses counted.
    repeat (5) drive_pulse(1, 1, 3);
    repeat (3) drive_pulse(1, 4, 3);
    repeat (4) tick();
    do_swap();
    check_eq("t2_sum", rd_sum_a, 3);
    check_eq("t2_local", rd_local_a, 0);
    rd_ready = 1; tick(); rd_ready = 0;

    // Unread shadow: the second swap is dropped and flagged.
    repeat (2) drive_pulse(0, 3, 3);
    repeat (4) tick();
    do_swap();
    drive_pulse(0, 3, 3);
    repeat (4) tick();
    do_swap();
    check_eq("t3_overrun", overrun_a, 1);
    check_eq("t3_held", rd_local_a, 2);
    check_eq("t3_valid", rd_valid_a, 1);
    rd_ready = 1; tick();
    check_eq("t3_drop", rd_valid_a, 0);

    // Hit landing on the swap edge belongs to the new frame.
    repeat (2) tick();
    disc_local = 1; tick(); tick(); tick();
    disc_local = 0;
    frame_swap = 1; tick(); frame_swap = 0;
    check_eq("t4_old", rd_local_a, 0);
    repeat (4) tick();
    do_swap();
    check_eq("t4_new", rd_local_a, 1);

    // Saturation on the narrow instance, cleared in the following frame.
    repeat (20) drive_pulse(0, 3, 3);
    repeat (4) tick();
    do_swap();
    check_eq("t5_sat_cnt", rd_local_b, 15);
    check_eq("t5_sat_flag", rd_sat_b[0], 1);
    check_eq("t5_wide", rd_local_a, 20);
    repeat (2) tick();
    do_swap();
    check_eq("t5_sat_clr", rd_sat_b, 0);

    // Reset in the middle of a pulse: outputs clear and that pulse is never counted.
    disc_local = 1; tick(); tick(); tick();
    rstn = 0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_overrun", overrun_a, 0);
    tick(); tick();
    rstn = 1;
    repeat (4) tick();
    disc_local = 0;
    repeat (6) tick();
    do_swap();
    check_eq("rst_pulse", rd_local_a, 0);
    check_eq("rst_valid", rd_valid_a, 1);

`ifdef PIXEL_COINC_EN
    // Local pulses inside sum pulses are coincident, those outside are not.
    repeat (8) begin
      disc_sum = 1; repeat (3) tick();
      disc_local = 1; repeat (3) tick();
      disc_local = 0; repeat (4) tick();
      disc_sum = 0; repeat (6) tick();
    end
    repeat (4) drive_pulse(0, 3, 6);
    repeat (4) tick();
    do_swap();
    check_eq("t6_coinc", rd_coinc_a, 8);
    check_eq("t6_local", rd_local_a, 12);
`endif

    // Randomised traffic with one asynchronous reset in the middle.
    for (int k = 0; k < 2500; k++) begin
      rand_drive();
      enable = ($urandom_range(0, 7) != 0);
      rd_ready = $urandom_range(0, 1);
      frame_swap = !frame_swap && ($urandom_range(0, 24) == 0);
      tick();
      if (k == 1200) begin
        rstn = 0;
        #1;
        model_reset();
        compare_all();
        tick();
        rstn = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
